// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences fetch/load/store requests onto a word-only
// unified memory. Sub-word stores are done as read-modify-write.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_fetch,
    input  logic        we_req,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] ir,
    output logic [31:0] rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q, wd_q, ir_q, rdata_q;
    logic [1:0]  size_q;
    logic        uns_q, fetch_q, err_q;
    logic        misal;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val, merged;

    // Alignment/legality of the incoming request; fetches are always word-sized
    always_comb begin
        misal = 1'b0;
        if (is_fetch) begin
            misal = (addr[1:0] != 2'b00);
        end else begin
            case (size)
                2'b00:   misal = 1'b0;
                2'b01:   misal = addr[0];
                2'b10:   misal = (addr[1:0] != 2'b00);
                default: misal = 1'b1;
            endcase
        end
    end

    // Load lane extraction/extension and store lane merge, both from mem_RD
    always_comb begin
        ld_b   = mem_RD[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        ld_val = mem_RD;
        case (size_q)
            2'b00:   ld_val = {{24{ld_b[7] & ~uns_q}}, ld_b};
            2'b01:   ld_val = {{16{ld_h[15] & ~uns_q}}, ld_h};
            default: ld_val = mem_RD;
        endcase
        merged = mem_RD;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and memory-side control
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        ack     = 1'b0;
        mem_WE  = 1'b0;
        mem_WD  = wd_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misal)                     state_n = DONE;
                    else if (is_fetch || !we_req)  state_n = RD;
                    else if (size == 2'b10)        state_n = WR;
                    else                           state_n = RMW_RD;
                end
            end
            RD:     begin busy = 1'b1; state_n = DONE; end
            RMW_RD: begin busy = 1'b1; state_n = RMW_WR; end
            RMW_WR: begin busy = 1'b1; mem_WE = ~rst; state_n = DONE; end
            WR:     begin busy = 1'b1; mem_WE = ~rst; mem_WD = wdata_q; state_n = DONE; end
            DONE:   begin ack = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
    end

    // Request capture, result registers and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            fetch_q <= 1'b0;
            err_q   <= 1'b0;
            ir_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        size_q  <= size;
                        uns_q   <= ld_unsigned;
                        fetch_q <= is_fetch;
                        // only an errored request touches err here; good ones clear it on completion
                        if (misal) err_q <= 1'b1;
                    end
                end
                RD: begin
                    if (fetch_q) ir_q    <= mem_RD;
                    else         rdata_q <= ld_val;
                    err_q <= 1'b0;
                end
                RMW_RD: wd_q <= merged;
                RMW_WR: err_q <= 1'b0;
                WR: begin
                    wd_q  <= wdata_q;   // keeps mem_WD stable after the write
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_A = {addr_q[31:2], 2'b00};
    assign err   = err_q;
    assign ir    = ir_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: memory model, byte-level reference model,
// directed vector table, reset/held-req sequences and random traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, req, is_fetch, we_req, ld_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, ack, err, mem_WE;
    logic [31:0] ir, rdata, mem_A, mem_WD, mem_RD;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req(req), .is_fetch(is_fetch), .we_req(we_req),
        .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .ir(ir), .rdata(rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // 4 KB word memory: combinational read, write on rising edge
    logic [31:0] mem [0:1023];
    logic        init_en;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            15:      return 32'h00F00513;
            600:     return 32'h80007F15;
            502:     return 32'h11223344;
            default: return i * 32'h9E3779B1;
        endcase
    endfunction

    assign mem_RD = mem[mem_A[11:2]];

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (mem_WE) begin
            mem[mem_A[11:2]] <= mem_WD;
        end
    end

    // Event counters sampled mid-cycle
    int we_cnt = 0;
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (mem_WE) we_cnt++;
        if (ack)    ack_cnt++;
    end

    // Reference model: byte array plus expected architectural registers
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_ir, exp_rd;
    logic        exp_err;

    function automatic logic [31:0] rword(input int a);
        int b;
        b = a & 32'hFFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // One request: predict, drive, and check latency/results
    task automatic run(input logic f, input logic we, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
        int lat, n, nc, we0, wexp;
        logic mis, got;
        logic [31:0] v;
        mis = f ? (a[1:0] != 2'b00)
                : (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
        n = 1 << sz;
        wexp = 0;
        if (mis) begin
            lat = 1; exp_err = 1'b1;
        end else if (f) begin
            lat = 2; exp_err = 1'b0; exp_ir = rword(int'(a));
        end else if (!we) begin
            lat = 2; exp_err = 1'b0; v = 0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
            if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
            exp_rd = v;
        end else begin
            lat = (n == 4) ? 2 : 3; exp_err = 1'b0; wexp = 1;
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
        end
        @(negedge clk);
        is_fetch = f; we_req = we; size = sz; ld_unsigned = u; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        we0 = we_cnt;
        nc = 0; got = 1'b0;
        while (!got && nc < 8) begin
            @(negedge clk);
            nc++;
            if (nc == 1 && !mis) chk("mem_A", mem_A, a & 32'hFFFFFFFC);
            if (ack) got = 1'b1;
        end
        chk("ack_latency", nc, lat);
        chk("err", err, exp_err);
        chk("busy_at_ack", busy, 1'b0);
        chk("ir", ir, exp_ir);
        chk("rdata", rdata, exp_rd);
        @(posedge clk);
        #1;
        chk("we_cycles", we_cnt - we0, wexp);
        chk("mem_word", mem[a[11:2]], rword(int'(a)));
    endtask

    typedef struct {
        logic        f, we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a, wd;
        int          kind;   // 0 ir, 1 rdata, 2 memory word, 3 err
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int a0;
        logic [31:0] ra, rw;
        logic [1:0]  rs;
        logic        rf, rwe;

        tbl[0]  = '{1, 0, 2'd2, 0, 32'd60,   32'd0,       0, 32'h00F00513};
        tbl[1]  = '{0, 0, 2'd0, 0, 32'd2403, 32'd0,       1, 32'hFFFFFF80};
        tbl[2]  = '{0, 0, 2'd0, 1, 32'd2403, 32'd0,       1, 32'h00000080};
        tbl[3]  = '{0, 0, 2'd1, 0, 32'd2400, 32'd0,       1, 32'h00007F15};
        tbl[4]  = '{0, 0, 2'd1, 0, 32'd2402, 32'd0,       1, 32'hFFFF8000};
        tbl[5]  = '{0, 1, 2'd2, 0, 32'd8,    32'd600,     2, 32'd600};
        tbl[6]  = '{0, 0, 2'd2, 0, 32'd8,    32'd0,       1, 32'd600};
        tbl[7]  = '{0, 1, 2'd0, 0, 32'd2009, 32'h000000AB, 2, 32'h1122AB44};
        tbl[8]  = '{0, 1, 2'd1, 0, 32'd2010, 32'h0000BEEF, 2, 32'hBEEFAB44};
        tbl[9]  = '{0, 0, 2'd2, 0, 32'd2010, 32'd0,       3, 32'd1};
        tbl[10] = '{0, 1, 2'd1, 0, 32'd61,   32'h00001234, 3, 32'd1};
        tbl[11] = '{0, 0, 2'd2, 0, 32'd2400, 32'd0,       1, 32'h80007F15};

        for (int i = 0; i < 1024; i++) begin
            rw = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = rw[8*k +: 8];
        end
        exp_ir = '0; exp_rd = '0; exp_err = 1'b0;

        rst = 1'b1; init_en = 1'b1; req = 1'b0; is_fetch = 1'b0; we_req = 1'b0;
        size = 2'd0; ld_unsigned = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_mem_WE", mem_WE, 1'b0);
        rst = 1'b0; init_en = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].f, tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
            case (tbl[i].kind)
                0:       chk($sformatf("tbl%0d_ir", i), ir, tbl[i].exp);
                1:       chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
                2:       chk($sformatf("tbl%0d_mem", i), mem[tbl[i].a[11:2]], tbl[i].exp);
                default: chk($sformatf("tbl%0d_err", i), {31'd0, err}, tbl[i].exp);
            endcase
        end

        // Reset landing in RMW_WR of a byte store: no write, no ack, outputs cleared
        @(negedge clk);
        is_fetch = 1'b0; we_req = 1'b1; size = 2'd0; ld_unsigned = 1'b0;
        addr = 32'd2009; wdata = 32'h00000055; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        a0 = ack_cnt;
        @(negedge clk);
        chk("rmw_rd_busy", busy, 1'b1);
        chk("rmw_rd_we", mem_WE, 1'b0);
        @(negedge clk);
        chk("rmw_wr_we", mem_WE, 1'b1);
        rst = 1'b1;
        #1 chk("we_gated_by_rst", mem_WE, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ir = '0; exp_rd = '0; exp_err = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_ack", ack, 1'b0);
        chk("postrst_err", err, 1'b0);
        chk("postrst_ir", ir, 32'd0);
        chk("postrst_rdata", rdata, 32'd0);
        chk("postrst_mem_A", mem_A, 32'd0);
        chk("postrst_mem_WD", mem_WD, 32'd0);
        chk("postrst_mem_WE", mem_WE, 1'b0);
        chk("postrst_mem", mem[502], rword(2008));
        repeat (3) @(negedge clk);
        #1 chk("postrst_no_ack", ack_cnt - a0, 0);

        // req held high: acks at cycles 2, 5, 8 only
        @(negedge clk);
        is_fetch = 1'b0; we_req = 1'b0; size = 2'd2; ld_unsigned = 1'b0;
        addr = 32'd8; wdata = '0; req = 1'b1;
        a0 = ack_cnt;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        req = 1'b0;
        #1 chk("held_req_acks", ack_cnt - a0, 3);
        exp_rd = rword(8);
        @(posedge clk);
        #1 chk("held_req_rdata", rdata, exp_rd);

        // Random traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            rf  = ($urandom_range(0, 3) == 0);
            rwe = $urandom_range(0, 1);
            rs  = 2'($urandom_range(0, 3));
            ra  = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0) begin
                if (rf || rs == 2'd2) ra = ra & 32'hFFC;
                else if (rs == 2'd1)  ra = ra & 32'hFFE;
            end
            rw = $urandom;
            run(rf, rwe, rs, $urandom_range(0, 1), ra, rw);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
